// File: rtl/mdu_pkg.sv
// Shared encodings and default width for the multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; purely combinational, no handshake.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + 1'b1) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit feeding HI/LO; result lands WIDTH+1 edges after start.
// start, MTHI and MTLO are only accepted in IDLE; anything arriving while busy is dropped.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic               isDiv, negProd, negQuot, negRem, divZero;
  logic [WIDTH-1:0]   opnd, aRaw, accHi, accLo;
  logic [WIDTH-1:0]   aAbs, bAbs, quoFix, remFix;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH:0]     sumMul, trial;
  logic               signedOp;

  assign signedOp = ~op[0];

  mdu_sign_fix #(.W(WIDTH))   uAbsA (.neg(signedOp & a[WIDTH-1]), .din(a), .dout(aAbs));
  mdu_sign_fix #(.W(WIDTH))   uAbsB (.neg(signedOp & b[WIDTH-1]), .din(b), .dout(bAbs));
  mdu_sign_fix #(.W(2*WIDTH)) uProd (.neg(negProd), .din({accHi, accLo}), .dout(prodFix));
  mdu_sign_fix #(.W(WIDTH))   uQuot (.neg(negQuot), .din(accLo), .dout(quoFix));
  mdu_sign_fix #(.W(WIDTH))   uRem  (.neg(negRem),  .din(accHi), .dout(remFix));

  // accHi/accLo serve as product halves when multiplying and as remainder/quotient when dividing.
  always_comb begin
    sumMul = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    trial  = {accHi, accLo[WIDTH-1]} - {1'b0, opnd};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      isDiv   <= 1'b0;
      negProd <= 1'b0;
      negQuot <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      opnd    <= '0;
      aRaw    <= '0;
      accHi   <= '0;
      accLo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            cnt     <= '0;
            isDiv   <= op[1];
            negProd <= (op == MDU_MULT) & (a[WIDTH-1] ^ b[WIDTH-1]);
            negQuot <= (op == MDU_DIV) & (a[WIDTH-1] ^ b[WIDTH-1]);
            negRem  <= (op == MDU_DIV) & a[WIDTH-1];
            divZero <= (b == '0);
            aRaw    <= a;
            opnd    <= op[1] ? bAbs : aAbs;
            accHi   <= '0;
            accLo   <= op[1] ? aAbs : bAbs;
          end
        end
        S_RUN: begin
          if (isDiv) begin
            if (!trial[WIDTH]) begin
              accHi <= trial[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], 1'b1};
            end else begin
              accHi <= {accHi[WIDTH-2:0], accLo[WIDTH-1]};
              accLo <= {accLo[WIDTH-2:0], 1'b0};
            end
          end else begin
            accHi <= sumMul[WIDTH:1];
            accLo <= {sumMul[0], accLo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= S_FIX;
        end
        S_FIX: begin
          if (!isDiv) begin
            {hi, lo} <= prodFix;
          end else if (divZero) begin
            hi <= aRaw;
            lo <= '1;
          end else begin
            hi <= remFix;
            lo <= quoFix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + random scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        CLK, RST, start, hi_we, lo_we, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] expQ[$];
  logic [31:0] modelHi, modelLo;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'b0, av};
    ub = {32'b0, bv};
    case (o)
      2'b00: begin p = sa * sb; return p; end
      2'b01: return ua * ub;
      2'b10: begin
        if (bv == 0) return {av, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (bv == 0) return {av, 32'hFFFFFFFF};
        p = ua % ub;
        ua = ua / ub;
        return {p[31:0], ua[31:0]};
      end
    endcase
  endfunction

  // Drives start for one edge and leaves the bench at edge k + 1 time unit.
  task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv, input logic [63:0] exp);
    op = o; a = av; b = bv; start = 1'b1;
    expQ.push_back(exp);
    @(posedge CLK); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  task automatic collect(input string tag, input int expLat);
    int n;
    bit busyDrop, bothHigh;
    logic [63:0] e;
    n = 0; busyDrop = 0; bothHigh = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busyDrop = 1;
      @(posedge CLK); #1;
      n++;
      if (busy === 1'b1 && done === 1'b1) bothHigh = 1;
    end
    chk({tag, "_latency"}, 64'(n), 64'(expLat));
    chk({tag, "_busyHeld"}, 64'(busyDrop), 64'd0);
    chk({tag, "_busyDoneOverlap"}, 64'(bothHigh), 64'd0);
    chk({tag, "_busyAtDone"}, 64'(busy), 64'd0);
    e = (expQ.size() > 0) ? expQ.pop_front() : 64'hx;
    chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    modelHi = e[63:32];
    modelLo = e[31:0];
    @(posedge CLK); #1;
    chk({tag, "_donePulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit sawDone, sawBusy;

    RST = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    modelHi = '0; modelLo = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    hi_we = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge CLK); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h00000042;
    @(posedge CLK); #1;
    lo_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hCAFEF00D);
    chk("mtlo_lo", 64'(lo), 64'h42);
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);

    launch(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    collect("multu_max", 33);
    launch(MDU_MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    collect("mult_neg", 33);
    launch(MDU_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    collect("div_neg", 33);

    // MTLO in the same IDLE cycle as start lands now, then FIX overwrites it.
    lo_we = 1'b1; wdata = 32'h55;
    launch(MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    lo_we = 1'b0;
    chk("mtlo_with_start", 64'(lo), 64'h55);
    collect("divu_100_7", 33);

    launch(MDU_DIVU, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
    collect("divu_zero", 33);
    launch(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    collect("div_ovf", 33);

    launch(MDU_MULTU, 32'd3, 32'd5, 64'd15);
    repeat (4) @(posedge CLK);
    #1;
    start = 1'b1; hi_we = 1'b1; wdata = 32'hDEADBEEF; op = MDU_DIVU; a = 32'd9; b = 32'd0;
    @(posedge CLK); #1;
    start = 1'b0; hi_we = 1'b0;
    chk("busy_mthi_ignored", 64'(hi), 64'(modelHi));
    collect("multu_ignore", 28);
    sawDone = 0; sawBusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) sawDone = 1;
      if (busy === 1'b1) sawBusy = 1;
    end
    chk("no_queued_done", 64'(sawDone), 64'd0);
    chk("no_queued_busy", 64'(sawBusy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 300)) : $urandom);
      launch(ro, ra, rb, refModel(ro, ra, rb));
      collect($sformatf("rand%0d_op%0d", i, ro), 33);
    end

    launch(MDU_MULTU, 32'h1234, 32'h5678, refModel(2'b01, 32'h1234, 32'h5678));
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    #2;
    expQ.delete();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    sawDone = 0; sawBusy = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) sawDone = 1;
      if (busy === 1'b1) sawBusy = 1;
    end
    chk("postrst_no_done", 64'(sawDone), 64'd0);
    chk("postrst_no_busy", 64'(sawBusy), 64'd0);
    chk("postrst_hi", 64'(hi), 64'd0);
    chk("postrst_lo", 64'(lo), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
